branch_sched: RTL and testbench
===============================

# branch_sched

ID-stage branch scheduler for the five-stage MIPS pipeline. Sequences the branch comparator:
- waits until the branch's source operands are forwardable, holding IF/ID while it waits;
- drives the comparator select and registers its verdict;
- issues a one-cycle PC redirect and, for bgezal, the $31 link write.

It sits between the ID-stage decoder/hazard unit and the PC/IF logic. Delay slots are architectural, so nothing is flushed.

## Interface
Parameters:
- PC_W, 32, PC/data width
- MAX_WAIT, 3, operand-wait cycles tolerated before hazard_err is raised

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state and outputs are forced to reset values immediately
- br_valid  in  1  ID holds a branch instruction
- br_type  in  3  0 beq, 1 bgezal, 2 bne, 3 bgez, 4 bltz; 5–7 invalid
- pc_id  in  PC_W  PC of the branch
- imm16  in  16  branch offset field
- rs_ready  in  1  rs value is forwardable this cycle
- rt_ready  in  1  rt value is forwardable this cycle
- cmp_sel  out  3  comparator select
- cmp_result  in  1  comparator verdict; combinational from cmp_sel and forwarded operands
- stall_id  out  1  freeze PC and IF/ID
- redirect_valid  out  1  one-cycle taken pulse
- redirect_pc  out  PC_W  branch target
- link_we  out  1  write $31
- link_addr  out  5  constant 31
- link_data  out  PC_W  pc_id+8
- hazard_err  out  1  sticky wait-timeout flag

## Operation
FSM states: IDLE, WAIT, RESOLVE.

Operand requirement (`need`):
- beq/bne: rs_ready & rt_ready
- all other types: rs_ready only

IDLE:
- br_valid=0: stay; stall_id=0.
- br_valid=1 & need met: accept.
  - stall_id=1, cmp_sel=br_type.
  - Capture cmp_result, br_type, target and pc_id+8.
  - Go to RESOLVE.
- br_valid=1 & need not met: stall_id=1; go to WAIT; wait_cnt=1.

WAIT:
- stall_id=1, cmp_sel=br_type.
- need met: accept exactly as in IDLE.
- br_valid drops (external flush): go to IDLE; no redirect, no link.
- Otherwise: wait_cnt increments, saturating.
  - When wait_cnt reaches MAX_WAIT, hazard_err sets and stays set until reset.
  - The FSM keeps waiting.

RESOLVE:
- stall_id=0.
- redirect_valid = captured taken.
- link_we=1 iff type is bgezal, regardless of outcome.
- Next state is IDLE.

Invalid types (5–7): resolve as not-taken with no link; still costs the accept cycle.

Target: pc_id + 4 + (sign_ext(imm16) << 2), modulo 2^PC_W; wrap-around is silent.

cmp_sel:
- br_type during IDLE/WAIT when br_valid=1.
- Latched type in RESOLVE.
- 3'd7 otherwise, so the comparator outputs 0.

## Timing
- Ready branch accepted in cycle N (stall_id=1).
- Redirect/link driven in cycle N+1 (stall_id=0); the delay slot enters ID at N+2.
- Minimum cost is 1 stall cycle per branch; each WAIT cycle adds 1.
- Back-to-back branches: the next accept is possible at N+2 (IDLE).
- redirect_pc, link_data and link_we are registered and valid only while redirect_valid or link_we is high; they hold their last value otherwise.
- Reset values:
  - stall_id=0, redirect_valid=0, redirect_pc=0, link_we=0, link_data=0, hazard_err=0, cmp_sel=7
  - FSM in IDLE, wait_cnt=0
- Reset asserted mid-WAIT or mid-RESOLVE: no redirect or link escapes. After release, the FSM starts in IDLE and re-evaluates br_valid.

## Configuration
- BRANCH_STAT_EN defined:
  - Adds outputs br_count and br_taken_count (32 bits each, reset 0, wrapping at 2^32).
  - br_count increments on each RESOLVE cycle for types 0–4; br_taken_count increments on each RESOLVE cycle that asserts redirect_valid.
- Undefined: these ports and counters are absent.

## Structure
- Shared package branch_pkg:
  - BR_BEQ..BR_BLTZ encodings and BR_NONE=3'd7
  - FSM state typedef
  - LINK_REG=5'd31
- One natural sub-module: br_target_calc, a combinational sign-extend/shift/add producing target and pc_id+8.

## Test plan
- Ready beq at pc_id=0x00003000, imm16=0x0004, cmp_result=1 -> stall_id=1 for 1 cycle, then redirect_valid pulse with redirect_pc=0x00003014; no link.
- bne, rs_ready=1, rt_ready=0 for 2 cycles -> stall_id high 3 cycles, cmp_sel=2 throughout, redirect issued on the 4th cycle; hazard_err stays 0.
- bgezal with cmp_result=0 at pc_id=0x00003100 -> no redirect; link_we=1, link_addr=31, link_data=0x00003108.
- bltz at pc_id=0xFFFFFFFC, imm16=0x0001, taken -> redirect_pc=0x00000004 (wrap).
- rs_ready held 0 for 4 cycles with MAX_WAIT=3 -> hazard_err sets on the 3rd wait cycle and persists. br_valid then dropping -> IDLE with no redirect.
- Reset pulsed during RESOLVE of a taken beq -> redirect_valid=0 immediately, all outputs at reset values, FSM in IDLE. With BRANCH_STAT_EN defined, br_count reads 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the ID-stage branch scheduler: branch types, FSM states, link register.
package branch_pkg;
  localparam logic [2:0] BR_BEQ    = 3'd0;
  localparam logic [2:0] BR_BGEZAL = 3'd1;
  localparam logic [2:0] BR_BNE    = 3'd2;
  localparam logic [2:0] BR_BGEZ   = 3'd3;
  localparam logic [2:0] BR_BLTZ   = 3'd4;
  localparam logic [2:0] BR_NONE   = 3'd7;
  localparam logic [4:0] LINK_REG  = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESOLVE} br_state_e;

  // Two-operand compares need rt forwarded as well as rs.
  function automatic logic needs_rt(input logic [2:0] t);
    return (t == BR_BEQ) || (t == BR_BNE);
  endfunction

  function automatic logic type_valid(input logic [2:0] t);
    return t <= BR_BLTZ;
  endfunction
endpackage

// File: rtl/br_target_calc.sv
// Branch target (pc+4+sext(imm)<<2) and link value (pc+8); wraps modulo 2^PC_W.
module br_target_calc #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc_id,
  input  logic [15:0]     imm16,
  output logic [PC_W-1:0] target,
  output logic [PC_W-1:0] link_pc
);
  logic [PC_W-1:0] offset;

  assign offset  = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign target  = pc_id + PC_W'(4) + offset;
  assign link_pc = pc_id + PC_W'(8);
endmodule

// File: rtl/branch_sched.sv
// ID-stage branch scheduler: operand wait, comparator sequencing, redirect/link issue.
// Optional BRANCH_STAT_EN adds br_count / br_taken_count statistics outputs.
module branch_sched import branch_pkg::*; #(
  parameter int PC_W     = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_valid,
  input  logic [2:0]      br_type,
  input  logic [PC_W-1:0] pc_id,
  input  logic [15:0]     imm16,
  input  logic            rs_ready,
  input  logic            rt_ready,
  output logic [2:0]      cmp_sel,
  input  logic            cmp_result,
  output logic            stall_id,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            link_we,
  output logic [4:0]      link_addr,
  output logic [PC_W-1:0] link_data,
  output logic            hazard_err
`ifdef BRANCH_STAT_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     br_taken_count
`endif
);
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  br_state_e       state;
  logic [CW-1:0]   wait_cnt, wait_nxt;
  logic [2:0]      res_type;
  logic            need, taken;
  logic [PC_W-1:0] target, link_pc;

  br_target_calc #(.PC_W(PC_W)) u_tgt (
    .pc_id   (pc_id),
    .imm16   (imm16),
    .target  (target),
    .link_pc (link_pc)
  );

  assign link_addr = LINK_REG;
  assign need      = rs_ready & (rt_ready | ~needs_rt(br_type));
  // Invalid types never redirect even if the comparator says otherwise.
  assign taken     = cmp_result & type_valid(br_type);
  assign wait_nxt  = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + CW'(1);

  // Stall and comparator select must react in the accept cycle itself.
  always_comb begin
    stall_id = 1'b0;
    cmp_sel  = BR_NONE;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          stall_id = br_valid;
          if (br_valid) cmp_sel = br_type;
        end
        S_WAIT: begin
          stall_id = 1'b1;
          if (br_valid) cmp_sel = br_type;
        end
        S_RESOLVE: cmp_sel = res_type;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      res_type       <= BR_NONE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_we        <= 1'b0;
      link_data      <= '0;
      hazard_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_WAIT: begin
          if (br_valid && need) begin
            state          <= S_RESOLVE;
            wait_cnt       <= '0;
            res_type       <= br_type;
            redirect_valid <= taken;
            link_we        <= (br_type == BR_BGEZAL);
            redirect_pc    <= target;
            link_data      <= link_pc;
          end else if (br_valid) begin
            state    <= S_WAIT;
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_MAX) hazard_err <= 1'b1;
          end else begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end
        end
        S_RESOLVE: begin
          state          <= S_IDLE;
          redirect_valid <= 1'b0;
          link_we        <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count       <= '0;
      br_taken_count <= '0;
    end else if (state == S_RESOLVE) begin
      if (type_valid(res_type)) br_count <= br_count + 32'd1;
      if (redirect_valid)       br_taken_count <= br_taken_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_sched.sv
// Self-checking bench for branch_sched: directed scenarios plus a randomized run vs a reference model.
module tb_branch_sched;
  localparam int PC_W     = 32;
  localparam int MAX_WAIT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            br_valid = 1'b0;
  logic [2:0]      br_type = 3'd0;
  logic [PC_W-1:0] pc_id = '0;
  logic [15:0]     imm16 = '0;
  logic            rs_ready = 1'b0, rt_ready = 1'b0, cmp_result = 1'b0;
  logic [2:0]      cmp_sel;
  logic            stall_id, redirect_valid, link_we, hazard_err;
  logic [PC_W-1:0] redirect_pc, link_data;
  logic [4:0]      link_addr;
`ifdef BRANCH_STAT_EN
  logic [31:0]     br_count, br_taken_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  branch_sched #(.PC_W(PC_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .br_valid       (br_valid),
    .br_type        (br_type),
    .pc_id          (pc_id),
    .imm16          (imm16),
    .rs_ready       (rs_ready),
    .rt_ready       (rt_ready),
    .cmp_sel        (cmp_sel),
    .cmp_result     (cmp_result),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .link_we        (link_we),
    .link_addr      (link_addr),
    .link_data      (link_data),
    .hazard_err     (hazard_err)
`ifdef BRANCH_STAT_EN
    ,
    .br_count       (br_count),
    .br_taken_count (br_taken_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] pc,
                       input logic [15:0] imm, input logic rs, input logic rt, input logic c);
    br_valid = v; br_type = t; pc_id = pc; imm16 = imm;
    rs_ready = rs; rt_ready = rt; cmp_result = c;
  endtask

  task automatic test_reset();
    drive(1'b1, 3'd0, 32'h1000, 16'h0001, 1'b1, 1'b1, 1'b1);
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall_id); end
    n_cmp++; if (cmp_sel !== 3'd7) begin n_fail++; $display("FAIL rst_cmp_sel: got %0d want 7", cmp_sel); end
    n_cmp++; if (redirect_valid !== 1'b0 || link_we !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got rv=%0b lwe=%0b want 0/0", redirect_valid, link_we); end
    n_cmp++; if (redirect_pc !== 32'h0 || link_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got rpc=%0h ld=%0h want 0/0", redirect_pc, link_data); end
    n_cmp++; if (hazard_err !== 1'b0) begin n_fail++; $display("FAIL rst_herr: got %0b want 0", hazard_err); end
    n_cmp++; if (link_addr !== 5'd31) begin n_fail++; $display("FAIL rst_link_addr: got %0d want 31", link_addr); end
    tick(); tick();
    br_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_beq_ready();
    drive(1'b1, 3'd0, 32'h0000_3000, 16'h0004, 1'b1, 1'b1, 1'b1);
    #1;
    n_cmp++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL beq_stall_n: got %0b want 1", stall_id); end
    n_cmp++; if (cmp_sel !== 3'd0) begin n_fail++; $display("FAIL beq_sel_n: got %0d want 0", cmp_sel); end
    tick();
    br_valid = 1'b0;
    #1;
    n_cmp++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL beq_stall_n1: got %0b want 0", stall_id); end
    n_cmp++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_rv: got %0b want 1", redirect_valid); end
    n_cmp++; if (redirect_pc !== 32'h0000_3014) begin n_fail++; $display("FAIL beq_rpc: got %0h want 3014", redirect_pc); end
    n_cmp++; if (link_we !== 1'b0) begin n_fail++; $display("FAIL beq_link: got %0b want 0", link_we); end
    n_cmp++; if (cmp_sel !== 3'd0) begin n_fail++; $display("FAIL beq_sel_res: got %0d want 0", cmp_sel); end
    tick();
    n_cmp++; if (redirect_valid !== 1'b0 || cmp_sel !== 3'd7) begin n_fail++; $display("FAIL beq_after: got rv=%0b sel=%0d want 0/7", redirect_valid, cmp_sel); end
    n_cmp++; if (redirect_pc !== 32'h0000_3014) begin n_fail++; $display("FAIL beq_rpc_hold: got %0h want 3014", redirect_pc); end
  endtask

  task automatic test_bne_wait();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 3'd2, 32'h0000_0200, 16'hFFFE, 1'b1, (c == 2), 1'b1);
      #1;
      n_cmp++; if (stall_id !== 1'b1 || cmp_sel !== 3'd2) begin n_fail++; $display("FAIL bne_wait_c%0d: got stall=%0b sel=%0d want 1/2", c, stall_id, cmp_sel); end
      n_cmp++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bne_early_rv_c%0d: got %0b want 0", c, redirect_valid); end
      tick();
    end
    br_valid = 1'b0;
    #1;
    n_cmp++; if (redirect_valid !== 1'b1 || stall_id !== 1'b0) begin n_fail++; $display("FAIL bne_res: got rv=%0b stall=%0b want 1/0", redirect_valid, stall_id); end
    n_cmp++; if (redirect_pc !== 32'h0000_01FC) begin n_fail++; $display("FAIL bne_rpc: got %0h want 1fc", redirect_pc); end
    n_cmp++; if (hazard_err !== 1'b0) begin n_fail++; $display("FAIL bne_herr: got %0b want 0", hazard_err); end
    tick();
  endtask

  task automatic test_bgezal_link();
    drive(1'b1, 3'd1, 32'h0000_3100, 16'h0010, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (stall_id !== 1'b1 || cmp_sel !== 3'd1) begin n_fail++; $display("FAIL bgezal_acc: got stall=%0b sel=%0d want 1/1", stall_id, cmp_sel); end
    tick();
    br_valid = 1'b0;
    #1;
    n_cmp++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bgezal_rv: got %0b want 0", redirect_valid); end
    n_cmp++; if (link_we !== 1'b1 || link_addr !== 5'd31) begin n_fail++; $display("FAIL bgezal_lwe: got we=%0b addr=%0d want 1/31", link_we, link_addr); end
    n_cmp++; if (link_data !== 32'h0000_3108) begin n_fail++; $display("FAIL bgezal_ld: got %0h want 3108", link_data); end
    tick();
    n_cmp++; if (link_we !== 1'b0 || link_data !== 32'h0000_3108) begin n_fail++; $display("FAIL bgezal_after: got we=%0b ld=%0h want 0/3108", link_we, link_data); end
  endtask

  task automatic test_bltz_wrap();
    drive(1'b1, 3'd4, 32'hFFFF_FFFC, 16'h0001, 1'b1, 1'b0, 1'b1);
    tick();
    br_valid = 1'b0;
    #1;
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0004) begin n_fail++; $display("FAIL bltz_wrap: got rv=%0b rpc=%0h want 1/4", redirect_valid, redirect_pc); end
    tick();
  endtask

  task automatic test_hazard_timeout();
    logic [3:0] exp_herr;
    exp_herr = 4'b1100;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 3'd3, 32'h0000_4000, 16'h0002, 1'b0, 1'b1, 1'b1);
      #1;
      n_cmp++; if (stall_id !== 1'b1) begin n_fail++; $display("FAIL haz_stall_c%0d: got %0b want 1", c, stall_id); end
      tick();
      n_cmp++; if (hazard_err !== exp_herr[c]) begin n_fail++; $display("FAIL haz_err_c%0d: got %0b want %0b", c, hazard_err, exp_herr[c]); end
    end
    br_valid = 1'b0;
    tick();
    #1;
    n_cmp++; if (redirect_valid !== 1'b0 || link_we !== 1'b0 || stall_id !== 1'b0) begin n_fail++; $display("FAIL haz_flush: got rv=%0b lwe=%0b stall=%0b want 0/0/0", redirect_valid, link_we, stall_id); end
    n_cmp++; if (hazard_err !== 1'b1) begin n_fail++; $display("FAIL haz_sticky: got %0b want 1", hazard_err); end
    tick();
  endtask

  task automatic test_reset_mid_resolve();
    drive(1'b1, 3'd0, 32'h0000_5000, 16'h0008, 1'b1, 1'b1, 1'b1);
    tick();
    n_cmp++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_rv: got %0b want 1", redirect_valid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (redirect_valid !== 1'b0 || stall_id !== 1'b0 || cmp_sel !== 3'd7) begin n_fail++; $display("FAIL rmid_out: got rv=%0b stall=%0b sel=%0d want 0/0/7", redirect_valid, stall_id, cmp_sel); end
    n_cmp++; if (redirect_pc !== 32'h0 || link_data !== 32'h0 || hazard_err !== 1'b0) begin n_fail++; $display("FAIL rmid_regs: got rpc=%0h ld=%0h herr=%0b want 0/0/0", redirect_pc, link_data, hazard_err); end
`ifdef BRANCH_STAT_EN
    n_cmp++; if (br_count !== 32'd0 || br_taken_count !== 32'd0) begin n_fail++; $display("FAIL rmid_stats: got %0d/%0d want 0/0", br_count, br_taken_count); end
`endif
    tick();
    reset = 1'b0;
    drive(1'b1, 3'd0, 32'h0000_6000, 16'h0000, 1'b1, 1'b1, 1'b0);
    #1;
    n_cmp++; if (stall_id !== 1'b1 || cmp_sel !== 3'd0) begin n_fail++; $display("FAIL rmid_reaccept: got stall=%0b sel=%0d want 1/0", stall_id, cmp_sel); end
    tick();
    br_valid = 1'b0;
    #1;
    n_cmp++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0000_6004) begin n_fail++; $display("FAIL rmid_nt: got rv=%0b rpc=%0h want 0/6004", redirect_valid, redirect_pc); end
    tick();
  endtask

  // Reference model: a branch either is resolving this cycle, waiting on operands, or absent.
  task automatic test_random();
    logic resolving, waiting, m_rv, m_lwe, m_herr, e_stall, need;
    logic [2:0] m_type, e_sel;
    logic [31:0] m_rpc, m_ld, m_brc, m_brt;
    int waited;
    reset = 1'b1; br_valid = 1'b0;
    #2;
    reset = 1'b0;
    tick();
    resolving = 0; waiting = 0; m_rv = 0; m_lwe = 0; m_herr = 0; m_type = 3'd7;
    m_rpc = 0; m_ld = 0; m_brc = 0; m_brt = 0; waited = 0;
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), $urandom, 16'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), 1'($urandom));
      #1;
      if (resolving) begin e_stall = 1'b0; e_sel = m_type; end
      else begin e_stall = waiting | br_valid; e_sel = br_valid ? br_type : 3'd7; end
      n_cmp++; if (stall_id !== e_stall || cmp_sel !== e_sel) begin n_fail++; $display("FAIL rnd_comb@%0d: got stall=%0b sel=%0d want %0b/%0d", i, stall_id, cmp_sel, e_stall, e_sel); end
      n_cmp++; if (redirect_valid !== m_rv || link_we !== m_lwe || hazard_err !== m_herr) begin n_fail++; $display("FAIL rnd_flags@%0d: got rv=%0b lwe=%0b herr=%0b want %0b/%0b/%0b", i, redirect_valid, link_we, hazard_err, m_rv, m_lwe, m_herr); end
      n_cmp++; if (redirect_pc !== m_rpc || link_data !== m_ld) begin n_fail++; $display("FAIL rnd_data@%0d: got rpc=%0h ld=%0h want %0h/%0h", i, redirect_pc, link_data, m_rpc, m_ld); end
`ifdef BRANCH_STAT_EN
      n_cmp++; if (br_count !== m_brc || br_taken_count !== m_brt) begin n_fail++; $display("FAIL rnd_stats@%0d: got %0d/%0d want %0d/%0d", i, br_count, br_taken_count, m_brc, m_brt); end
`endif
      if (resolving) begin
        if (m_type <= 3'd4) m_brc = m_brc + 1;
        if (m_rv) m_brt = m_brt + 1;
        resolving = 0; m_rv = 0; m_lwe = 0;
      end else if (br_valid) begin
        need = rs_ready && (rt_ready || !(br_type == 3'd0 || br_type == 3'd2));
        if (need) begin
          resolving = 1; waiting = 0; waited = 0; m_type = br_type;
          m_rv  = cmp_result && (br_type <= 3'd4);
          m_lwe = (br_type == 3'd1);
          m_rpc = pc_id + 32'd4 + 32'(int'($signed(imm16)) * 4);
          m_ld  = pc_id + 32'd8;
        end else begin
          waiting = 1;
          if (waited < MAX_WAIT) waited++;
          if (waited >= MAX_WAIT) m_herr = 1;
        end
      end else begin
        waiting = 0; waited = 0;
      end
      tick();
    end
    br_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_beq_ready();
    test_bne_wait();
    test_bgezal_link();
    test_bltz_wrap();
    test_hazard_timeout();
    test_reset_mid_resolve();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
